// File: rtl/dmem_block_mover.sv
// Block copy/fill initiator for the single-port data memory.
// Keeps a running 16-bit sum of the written words and reports it with done.
module dmem_block_mover #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, WR, FIN
  } state_t;

  state_t                state;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] fill_q;

  // mem_wdata doubles as the copy buffer: it is loaded from mem_rdata
  // at the end of CAP and presented unchanged throughout WR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mode_q       <= 1'b0;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      remaining    <= '0;
      fill_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      checksum     <= '0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      mem_write_en <= 1'b0;
    end else begin
      done         <= 1'b0;
      mem_write_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= length;
            fill_q    <= fill_value;
            checksum  <= '0;
            busy      <= 1'b1;
            if (length == '0) begin
              state <= FIN;
            end else if (mode) begin
              state        <= WR;
              mem_address  <= dst_addr;
              mem_wdata    <= fill_value;
              mem_write_en <= 1'b1;
            end else begin
              state       <= RD;
              mem_address <= src_addr;
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          state        <= WR;
          src_ptr      <= src_ptr + ADDR_WIDTH'(1);
          mem_address  <= dst_ptr;
          mem_wdata    <= mem_rdata;
          mem_write_en <= 1'b1;
        end
        WR: begin
          checksum  <= checksum + mem_wdata;
          dst_ptr   <= dst_ptr + ADDR_WIDTH'(1);
          remaining <= remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) begin
            state <= FIN;
          end else if (mode_q) begin
            mem_address  <= dst_ptr + ADDR_WIDTH'(1);
            mem_wdata    <= fill_q;
            mem_write_en <= 1'b1;
          end else begin
            state       <= RD;
            mem_address <= src_ptr;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
